// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access types, op direction,
// FSM states and helpers that decode access size/signedness from funct3.
package load_store_unit_pkg;

  localparam logic [2:0] TYP_B  = 3'd0;
  localparam logic [2:0] TYP_H  = 3'd1;
  localparam logic [2:0] TYP_W  = 3'd2;
  localparam logic [2:0] TYP_BU = 3'd4;
  localparam logic [2:0] TYP_HU = 3'd5;

  localparam logic FCN_LOAD  = 1'b0;
  localparam logic FCN_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  // Unused funct3 codes (3/6/7) fall through to word accesses.
  function automatic mem_size_e typ_size(input logic [2:0] typ);
    case (typ)
      TYP_B, TYP_BU: return SZ_B;
      TYP_H, TYP_HU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic logic typ_unsigned(input logic [2:0] typ);
    return (typ == TYP_BU) || (typ == TYP_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Extracts the addressed byte/half from a raw read word and sign- or
// zero-extends it to 32 bits.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  typ,
  output logic [31:0] result
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = raw[8*gi +: 8];
  end

  always_comb begin
    byte_sel = lane[addr_lo];
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
    sext     = !typ_unsigned(typ);
    case (typ_size(typ))
      SZ_B:    result = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_H:    result = {{16{sext & half_sel[15]}}, half_sel};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: checks alignment, issues one memory
// access per op, aligns load data and bounds the wait for a response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic        io_req_fcn,
  input  logic [2:0]  io_req_typ,
  input  logic [31:0] io_req_addr,
  input  logic [31:0] io_req_wdata,
  output logic        io_mem_req_valid,
  input  logic        io_mem_req_ready,
  output logic [31:0] io_mem_req_addr,
  output logic        io_mem_req_wen,
  output logic [3:0]  io_mem_req_wmask,
  output logic [31:0] io_mem_req_wdata,
  input  logic        io_mem_resp_valid,
  input  logic [31:0] io_mem_resp_data,
  output logic [31:0] io_wb_mem,
  output logic        io_wb_valid,
  output logic        io_stall,
  output logic        io_exc_misaligned,
  output logic        io_exc_fault
);

  localparam int CNT_W = $clog2(MAX_WAIT + 2);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  lsu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             fcn_reg;
  logic [2:0]       typ_reg;
  logic [31:0]      addr_reg, wdata_reg;
  logic [31:0]      wb_mem_reg;
  logic             exc_mis_reg, exc_fault_reg;

  logic             misaligned, accept, fault_fire, load_done;
  logic [31:0]      load_result, store_data;
  logic [3:0]       wmask;
  mem_size_e        req_size, store_size;

  assign req_size   = typ_size(io_req_typ);
  assign misaligned = ((req_size == SZ_H) && io_req_addr[0]) ||
                      ((req_size == SZ_W) && (io_req_addr[1:0] != 2'b00));
  assign accept     = (state_reg == ST_IDLE) && io_req_valid && !misaligned;

  load_align u_load_align (
    .raw     (io_mem_resp_data),
    .addr_lo (addr_reg[1:0]),
    .typ     (typ_reg),
    .result  (load_result)
  );

  always_comb begin
    state_next = state_reg;
    fault_fire = 1'b0;
    load_done  = 1'b0;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_REQ;
      ST_REQ:  if (io_mem_req_ready) state_next = (fcn_reg == FCN_STORE) ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        // A response on the final allowed cycle still completes the load.
        if (io_mem_resp_valid) begin
          load_done  = 1'b1;
          state_next = ST_DONE;
        end else if (cnt_reg == MAX_CNT) begin
          fault_fire = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      fcn_reg       <= FCN_LOAD;
      typ_reg       <= TYP_W;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wb_mem_reg    <= '0;
      exc_mis_reg   <= 1'b0;
      exc_fault_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      exc_mis_reg   <= (state_reg == ST_IDLE) && io_req_valid && misaligned;
      exc_fault_reg <= fault_fire;
      cnt_reg       <= (state_reg == ST_WAIT) ? cnt_reg + 1'b1 : '0;
      if (accept) begin
        fcn_reg   <= io_req_fcn;
        typ_reg   <= io_req_typ;
        addr_reg  <= io_req_addr;
        wdata_reg <= io_req_wdata;
      end
      if (load_done) wb_mem_reg <= load_result;
    end
  end

  assign store_size = typ_size(typ_reg);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_store_lane
    assign store_data[8*gi +: 8] = (store_size == SZ_B) ? wdata_reg[7:0] :
                                   (store_size == SZ_H) ? wdata_reg[8*(gi%2) +: 8] :
                                                          wdata_reg[8*gi +: 8];
  end

  always_comb begin
    wmask = 4'h0;
    if (fcn_reg == FCN_STORE) begin
      case (store_size)
        SZ_B:    wmask = 4'b0001 << addr_reg[1:0];
        SZ_H:    wmask = 4'b0011 << {addr_reg[1], 1'b0};
        default: wmask = 4'hF;
      endcase
    end
  end

  assign io_req_ready      = (state_reg == ST_IDLE);
  assign io_mem_req_valid  = (state_reg == ST_REQ);
  assign io_mem_req_addr   = {addr_reg[31:2], 2'b00};
  assign io_mem_req_wen    = (fcn_reg == FCN_STORE);
  assign io_mem_req_wmask  = wmask;
  assign io_mem_req_wdata  = store_data;
  assign io_wb_mem         = wb_mem_reg;
  assign io_wb_valid       = (state_reg == ST_DONE);
  assign io_stall          = (state_reg != ST_IDLE) || accept;
  assign io_exc_misaligned = exc_mis_reg;
  assign io_exc_fault      = exc_fault_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a behavioural model of alignment,
// extension, store lane placement, latency and wait-timeout rules.
module tb_load_store_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_req_valid = 1'b0;
  logic        io_req_ready;
  logic        io_req_fcn = 1'b0;
  logic [2:0]  io_req_typ = 3'd0;
  logic [31:0] io_req_addr = '0;
  logic [31:0] io_req_wdata = '0;
  logic        io_mem_req_valid;
  logic        io_mem_req_ready = 1'b0;
  logic [31:0] io_mem_req_addr;
  logic        io_mem_req_wen;
  logic [3:0]  io_mem_req_wmask;
  logic [31:0] io_mem_req_wdata;
  logic        io_mem_resp_valid = 1'b0;
  logic [31:0] io_mem_resp_data = '0;
  logic [31:0] io_wb_mem;
  logic        io_wb_valid;
  logic        io_stall;
  logic        io_exc_misaligned;
  logic        io_exc_fault;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  logic [31:0] model_wb = '0;

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk               (clk),
    .reset             (reset),
    .io_req_valid      (io_req_valid),
    .io_req_ready      (io_req_ready),
    .io_req_fcn        (io_req_fcn),
    .io_req_typ        (io_req_typ),
    .io_req_addr       (io_req_addr),
    .io_req_wdata      (io_req_wdata),
    .io_mem_req_valid  (io_mem_req_valid),
    .io_mem_req_ready  (io_mem_req_ready),
    .io_mem_req_addr   (io_mem_req_addr),
    .io_mem_req_wen    (io_mem_req_wen),
    .io_mem_req_wmask  (io_mem_req_wmask),
    .io_mem_req_wdata  (io_mem_req_wdata),
    .io_mem_resp_valid (io_mem_resp_valid),
    .io_mem_resp_data  (io_mem_resp_data),
    .io_wb_mem         (io_wb_mem),
    .io_wb_valid       (io_wb_valid),
    .io_stall          (io_stall),
    .io_exc_misaligned (io_exc_misaligned),
    .io_exc_fault      (io_exc_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (io_mem_req_valid && io_mem_req_ready) acc_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_size(input logic [2:0] typ);
    if (typ == 3'd0 || typ == 3'd4) return 1;
    if (typ == 3'd1 || typ == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] typ, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * addr[1:0]);
    case (typ)
      3'd0:    return 32'($signed(v[7:0]));
      3'd1:    return 32'($signed(v[15:0]));
      3'd4:    return {24'd0, v[7:0]};
      3'd5:    return {16'd0, v[15:0]};
      default: return word;
    endcase
  endfunction

  task automatic randomize_req_fields();
    io_req_fcn   = 1'($urandom);
    io_req_typ   = 3'($urandom);
    io_req_addr  = $urandom;
    io_req_wdata = $urandom;
  endtask

  // resp_d > MW means the memory never answers.
  task automatic run_op(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word,
                        input int rdy_d, input int resp_d);
    int sz, acc0, acc_cyc;
    logic mis;
    logic [31:0] exp_ld, exp_mask, exp_wd, word_addr;
    sz        = ref_size(typ);
    mis       = (int'(addr[1:0]) % sz) != 0;
    exp_ld    = ref_load(typ, addr, word);
    word_addr = addr - 32'(addr[1:0]);
    exp_mask  = !fcn ? 32'h0 : (sz == 4) ? 32'hF : (sz == 2 ? 32'h3 : 32'h1) << addr[1:0];
    exp_wd    = (sz == 1) ? wdata[7:0] * 32'h0101_0101 :
                (sz == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
    $display("op %s typ=%0d addr=%08h wdata=%08h word=%08h rdy_d=%0d resp_d=%0d",
             fcn ? "ST" : "LD", typ, addr, wdata, word, rdy_d, resp_d);

    @(posedge clk); #1;
    acc0 = acc_cnt;
    io_req_valid = 1'b1;
    io_req_fcn   = fcn;
    io_req_typ   = typ;
    io_req_addr  = addr;
    io_req_wdata = wdata;
    @(negedge clk);
    check("idle_req_ready", 32'(io_req_ready), 32'd1);
    check("idle_stall", 32'(io_stall), 32'(!mis));
    acc_cyc = cyc;
    @(posedge clk); #1;
    io_req_valid = 1'b0;
    randomize_req_fields();

    if (mis) begin
      @(negedge clk);
      check("misaligned_pulse", 32'(io_exc_misaligned), 32'd1);
      check("misaligned_no_mem", 32'(io_mem_req_valid), 32'd0);
      check("misaligned_idle", 32'(io_req_ready), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("misaligned_pulse_end", 32'(io_exc_misaligned), 32'd0);
    end else begin
      for (int k = 0; k <= rdy_d; k++) begin
        io_mem_req_ready  = (k == rdy_d);
        io_mem_resp_valid = 1'($urandom);
        io_mem_resp_data  = $urandom;
        @(negedge clk);
        check("req_valid", 32'(io_mem_req_valid), 32'd1);
        check("req_ready_low", 32'(io_req_ready), 32'd0);
        check("req_stall", 32'(io_stall), 32'd1);
        check("req_addr", io_mem_req_addr, word_addr);
        check("req_wen", 32'(io_mem_req_wen), 32'(fcn));
        check("req_wmask", 32'(io_mem_req_wmask), exp_mask);
        if (fcn) check("req_wdata", io_mem_req_wdata, exp_wd);
        @(posedge clk); #1;
      end
      io_mem_req_ready  = 1'b0;
      io_mem_resp_valid = 1'b0;

      if (fcn) begin
        @(negedge clk);
        check("st_wb_valid", 32'(io_wb_valid), 32'd1);
        check("st_latency", 32'(cyc - acc_cyc), 32'(2 + rdy_d));
        check("st_wb_mem_kept", io_wb_mem, model_wb);
        check("st_done_stall", 32'(io_stall), 32'd1);
      end else if (resp_d <= MW) begin
        for (int k = 0; k <= resp_d; k++) begin
          io_mem_resp_valid = (k == resp_d);
          io_mem_resp_data  = (k == resp_d) ? word : $urandom;
          @(negedge clk);
          check("wait_stall", 32'(io_stall), 32'd1);
          check("wait_no_wb", 32'(io_wb_valid), 32'd0);
          @(posedge clk); #1;
        end
        io_mem_resp_valid = 1'b0;
        io_mem_resp_data  = $urandom;
        model_wb = exp_ld;
        @(negedge clk);
        check("ld_wb_valid", 32'(io_wb_valid), 32'd1);
        check("ld_latency", 32'(cyc - acc_cyc), 32'(3 + rdy_d + resp_d));
        check("ld_wb_mem", io_wb_mem, model_wb);
        check("ld_done_stall", 32'(io_stall), 32'd1);
      end else begin
        for (int k = 0; k <= MW; k++) begin
          @(negedge clk);
          check("fault_wait_stall", 32'(io_stall), 32'd1);
          check("fault_no_early", 32'(io_exc_fault), 32'd0);
          @(posedge clk); #1;
        end
        @(negedge clk);
        check("fault_pulse", 32'(io_exc_fault), 32'd1);
        check("fault_no_wb", 32'(io_wb_valid), 32'd0);
        check("fault_idle", 32'(io_req_ready), 32'd1);
        check("fault_wb_kept", io_wb_mem, model_wb);
        @(posedge clk); #1;
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data  = $urandom;
        @(negedge clk);
        check("fault_pulse_end", 32'(io_exc_fault), 32'd0);
        @(posedge clk); #1;
        io_mem_resp_valid = 1'b0;
        @(negedge clk);
        check("late_resp_no_wb", 32'(io_wb_valid), 32'd0);
        check("late_resp_wb_kept", io_wb_mem, model_wb);
      end

      if (fcn || resp_d <= MW) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("after_done_wb_valid", 32'(io_wb_valid), 32'd0);
        check("after_done_stall", 32'(io_stall), 32'd0);
        check("after_done_idle", 32'(io_req_ready), 32'd1);
      end
    end
    check("access_count", 32'(acc_cnt - acc0), mis ? 32'd0 : 32'd1);
  endtask

  initial begin
    logic [2:0]  r_typ;
    logic [31:0] r_addr;
    int          r_resp;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(io_req_ready), 32'd1);
    check("rst_wb_mem", io_wb_mem, 32'd0);
    check("rst_wb_valid", 32'(io_wb_valid), 32'd0);
    check("rst_exc_mis", 32'(io_exc_misaligned), 32'd0);
    check("rst_exc_fault", 32'(io_exc_fault), 32'd0);
    check("rst_mem_req_valid", 32'(io_mem_req_valid), 32'd0);
    check("rst_stall", 32'(io_stall), 32'd0);

    run_op(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 0);
    run_op(1'b0, 3'd5, 32'h0000_0102, 32'h0, 32'h8001_1234, 0, 0);
    run_op(1'b0, 3'd1, 32'h0000_0102, 32'h0, 32'h8001_1234, 0, 0);
    run_op(1'b1, 3'd0, 32'h0000_0201, 32'h0000_00AB, 32'h0, 0, 0);
    run_op(1'b0, 3'd2, 32'h0000_0102, 32'h0, 32'h0, 0, 0);
    run_op(1'b0, 3'd2, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 0, MW + 1);
    run_op(1'b0, 3'd2, 32'h0000_0404, 32'h0, 32'h1234_5678, 0, 0);
    run_op(1'b0, 3'd4, 32'h0000_0501, 32'h0, 32'h0000_F100, 0, MW);
    run_op(1'b1, 3'd1, 32'h0000_0602, 32'hCAFE_BABE, 32'h0, 5, 0);
    run_op(1'b1, 3'd2, 32'h0000_0700, 32'h0BAD_F00D, 32'h0, 5, 0);

    for (int i = 0; i < 60; i++) begin
      r_typ  = 3'($urandom);
      r_addr = $urandom;
      r_resp = ($urandom_range(0, 9) == 0) ? MW + 1 : int'($urandom_range(0, MW));
      run_op(1'($urandom), r_typ, r_addr, $urandom, $urandom, int'($urandom_range(0, 3)), r_resp);
    end

    // Reset while waiting for a response abandons the load.
    @(posedge clk); #1;
    io_req_valid = 1'b1;
    io_req_fcn   = 1'b0;
    io_req_typ   = 3'd2;
    io_req_addr  = 32'h0000_0300;
    @(posedge clk); #1;
    io_req_valid     = 1'b0;
    io_mem_req_ready = 1'b1;
    @(posedge clk); #1;
    io_mem_req_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_wb = 32'h0;
    io_mem_resp_valid = 1'b1;
    io_mem_resp_data  = 32'h5555_AAAA;
    @(negedge clk);
    check("rst_abandon_idle", 32'(io_req_ready), 32'd1);
    check("rst_abandon_no_mem", 32'(io_mem_req_valid), 32'd0);
    @(posedge clk); #1;
    io_mem_resp_valid = 1'b0;
    @(negedge clk);
    check("rst_abandon_no_wb", 32'(io_wb_valid), 32'd0);
    check("rst_abandon_wb_mem", io_wb_mem, model_wb);

    run_op(1'b0, 3'd2, 32'h0000_0308, 32'h0, 32'h7777_0001, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: cycles allowed in WAIT before an access fault.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-003 io_req_valid  input  1  pipeline memory op present.
REQ-004 io_req_ready  output 1  op accepted this cycle.
REQ-005 io_req_fcn  input  1  0=load, 1=store.
REQ-006 io_req_typ  input  3  funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU; 3/6/7 treated as W.
REQ-007 io_req_addr  input  32  byte address.
REQ-008 io_req_wdata  input  32  store data, LSB-justified.
REQ-009 io_mem_req_valid / io_mem_req_ready  output/input  1  memory request handshake.
REQ-010 io_mem_req_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-011 io_mem_req_wen  output 1; io_mem_req_wmask  output 4; io_mem_req_wdata  output 32.
REQ-012 io_mem_resp_valid  input 1; io_mem_resp_data  input 32  raw read word.
REQ-013 io_wb_mem  output  32  aligned, extended load result to writeback select.
REQ-014 io_wb_valid  output  1  one-cycle completion pulse (load or store).
REQ-015 io_stall  output  1  hold the pipeline.
REQ-016 io_exc_misaligned / io_exc_fault  output  1  one-cycle exception pulses.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DONE.
REQ-018 IDLE: io_req_ready=1; all other states io_req_ready=0.
REQ-019 IDLE with io_req_valid: H/HU with addr[0]=1, or W with addr[1:0]!=0, SHALL pulse io_exc_misaligned next cycle, issue no memory access, stay IDLE.
REQ-020 IDLE with valid, aligned op: latch fcn/typ/addr/wdata, go REQ.
REQ-021 REQ: io_mem_req_valid=1, outputs from latched values held stable until io_mem_req_ready; on handshake, store -> DONE, load -> WAIT.
REQ-022 Store wmask/wdata: B -> 4'b0001<<addr[1:0], byte replicated x4; H -> 4'b0011<<{addr[1],1'b0}, half replicated x2; W -> 4'hF, wdata as is. Loads: wen=0, wmask=0.
REQ-023 WAIT: on io_mem_resp_valid, select byte/half by latched addr[1:0], sign-extend (B,H) or zero-extend (BU,HU), register into io_wb_mem, go DONE.
REQ-024 io_mem_resp_valid outside WAIT SHALL be ignored.
REQ-025 WAIT counter counts from 0 on entry; when it reaches MAX_WAIT without a response, pulse io_exc_fault, go IDLE, io_wb_mem unchanged.
REQ-026 Response arriving on the same cycle the counter reaches MAX_WAIT SHALL be accepted (response wins, no fault).
REQ-027 DONE: io_wb_valid=1 for exactly one cycle, then IDLE.
REQ-028 io_wb_mem SHALL hold its value until the next load completes; stores do not modify it.
REQ-029 io_stall = (state!=IDLE) or (IDLE and io_req_valid and op aligned); 0 in DONE is NOT permitted -- stall is high in DONE, low the cycle after.
REQ-030 Latency with zero-wait memory: load accepted cycle N -> io_wb_valid cycle N+3; store -> cycle N+2.

Reset
REQ-031 On reset: state IDLE, counter 0, io_wb_mem 0, io_wb_valid 0, both exception pulses 0, io_mem_req_valid 0.
REQ-032 Reset asserted in REQ/WAIT SHALL abandon the access; a later io_mem_resp_valid is ignored per REQ-024.

Structure
REQ-033 Shared package SHALL hold typ encodings, fcn encodings, FSM state encoding.
REQ-034 Combinational sub-module load_align (raw word, addr[1:0], typ -> 32-bit result) SHALL implement REQ-023 extraction.

Verification
REQ-035 LB addr 0x103, resp 0x80FF_FFFF -> io_wb_mem 0xFFFF_FF80, io_wb_valid at N+3.
REQ-036 LHU addr 0x102, resp 0x8001_1234 -> io_wb_mem 0x0000_8001; LH same -> 0xFFFF_8001.
REQ-037 SB addr 0x201, wdata 0x0000_00AB -> wmask 4'b0010, wdata 0xABAB_ABAB, addr 0x200, wen=1; io_wb_mem unchanged.
REQ-038 LW addr 0x102 -> io_exc_misaligned pulse, no io_mem_req_valid, state IDLE.
REQ-039 MAX_WAIT=4, load, no response -> io_exc_fault after 4 WAIT cycles; late response ignored; next LW completes normally.
REQ-040 io_mem_req_ready held low 5 cycles in REQ -> addr/wmask/wdata stable throughout, io_stall high, single access issued.
